// File: rtl/agnus_chipbus_seq_pkg.sv
`default_nettype none
// ============================================================================
//  agnus_chipbus_seq_pkg
//  Shared encodings and constants for the Agnus chip-bus cycle sequencer.
//  Revision: 1.0
// ============================================================================
package agnus_chipbus_seq_pkg;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_dma_busy = 2'd1;
    localparam logic [1:0] c_st_cpu_busy = 2'd2;

    localparam int          c_timeout_default = 15;
    localparam logic [15:0] c_bus_err_fill    = 16'hFFFF;

    // A CPU access with neither strobe set is treated as a full-word access.
    function automatic logic [1:0] cpu_be(input logic uds, input logic lds);
        return ({uds, lds} == 2'b00) ? 2'b11 : {uds, lds};
    endfunction

endpackage
`default_nettype wire

// File: rtl/agnus_chipbus_latch.sv
`default_nettype none
// ============================================================================
//  agnus_chipbus_latch
//  Transaction capture register: selects DMA or CPU source on slot accept.
//  Revision: 1.0
// ============================================================================
module agnus_chipbus_latch
    import agnus_chipbus_seq_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          _reset,
    input  logic          i_load,
    input  logic          i_sel_dma,
    input  logic [AW-1:0] i_dma_address,
    input  logic [15:0]   i_dma_wdata,
    input  logic          i_dma_we,
    input  logic [AW-1:0] i_cpu_address,
    input  logic [15:0]   i_cpu_wdata,
    input  logic          i_cpu_we,
    input  logic          i_cpu_uds,
    input  logic          i_cpu_lds,
    output logic [AW-1:0] o_address,
    output logic [15:0]   o_wdata,
    output logic          o_we,
    output logic [1:0]    o_be
);

    logic [AW-1:0] r_address;
    logic [15:0]   r_wdata;
    logic          r_we;
    logic [1:0]    r_be;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_address <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_be      <= 2'b00;
        end else if (i_load) begin
            if (i_sel_dma) begin
                r_address <= i_dma_address;
                r_wdata   <= i_dma_wdata;
                r_we      <= i_dma_we;
                r_be      <= 2'b11;
            end else begin
                r_address <= i_cpu_address;
                r_wdata   <= i_cpu_wdata;
                r_we      <= i_cpu_we;
                r_be      <= cpu_be(i_cpu_uds, i_cpu_lds);
            end
        end
    end

    assign o_address = r_address;
    assign o_wdata   = r_wdata;
    assign o_we      = r_we;
    assign o_be      = r_be;

endmodule
`default_nettype wire

// File: rtl/agnus_chipbus_seq.sv
`default_nettype none
// ============================================================================
//  agnus_chipbus_seq
//  Per-slot chip-bus sequencer arbitrating Agnus DMA and CPU onto a req/ack port.
//  Revision: 1.0
// ============================================================================
module agnus_chipbus_seq
    import agnus_chipbus_seq_pkg::*;
#(
    parameter int TIMEOUT = c_timeout_default,
    parameter int AW      = 20
) (
    input  logic          clk,
    input  logic          _reset,
    input  logic          clk7_en,
    input  logic          dbr,
    input  logic          dbwe,
    input  logic [AW-1:0] dma_address,
    input  logic [15:0]   dma_wdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [15:0]   cpu_wdata,
    input  logic          cpu_uds,
    input  logic          cpu_lds,
    output logic          cpu_ack,
    output logic [15:0]   cpu_rdata,
    output logic [15:0]   chip_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_address,
    output logic [15:0]   mem_wdata,
    output logic [1:0]    mem_be,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic          bls,
    output logic          timeout_err
);

    localparam int             c_tw     = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tlimit = c_tw'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [c_tw-1:0] r_tcnt;
    logic            r_cpu_ack;
    logic [15:0]     r_cpu_rdata;
    logic [15:0]     r_chip_rdata;
    logic            r_bls;
    logic            r_timeout_err;

    logic w_idle, w_in_dma, w_in_cpu;
    logic w_accept_dma, w_accept_cpu, w_load;
    logic w_overrun, w_done, w_timeout;

    assign w_idle       = (r_state == c_st_idle);
    assign w_in_dma     = (r_state == c_st_dma_busy);
    assign w_in_cpu     = (r_state == c_st_cpu_busy);
    assign w_accept_dma = w_idle & clk7_en & dbr;
    assign w_accept_cpu = w_idle & clk7_en & ~dbr & cpu_req;
    assign w_load       = w_accept_dma | w_accept_cpu;
    assign w_done       = ~w_idle & mem_ack;
    // A slot tick landing during a busy cycle is lost; it only ages the cycle.
    assign w_overrun    = ~w_idle & clk7_en;
    assign w_timeout    = w_overrun & ~mem_ack & (r_tcnt == c_tlimit);

    agnus_chipbus_latch #(.AW(AW)) u_latch (
        .clk           (clk),
        ._reset        (_reset),
        .i_load        (w_load),
        .i_sel_dma     (dbr),
        .i_dma_address (dma_address),
        .i_dma_wdata   (dma_wdata),
        .i_dma_we      (dbwe),
        .i_cpu_address (cpu_address),
        .i_cpu_wdata   (cpu_wdata),
        .i_cpu_we      (cpu_we),
        .i_cpu_uds     (cpu_uds),
        .i_cpu_lds     (cpu_lds),
        .o_address     (mem_address),
        .o_wdata       (mem_wdata),
        .o_we          (mem_we),
        .o_be          (mem_be)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) r_state <= c_st_idle;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept_dma)      w_state_next = c_st_dma_busy;
                else if (w_accept_cpu) w_state_next = c_st_cpu_busy;
            end
            c_st_dma_busy, c_st_cpu_busy: begin
                if (w_done || w_timeout) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        mem_req = ~w_idle;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_tcnt        <= '0;
            r_cpu_ack     <= 1'b0;
            r_cpu_rdata   <= 16'h0000;
            r_chip_rdata  <= 16'h0000;
            r_bls         <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_cpu_ack <= w_in_cpu & (w_done | w_timeout);

            if (w_load || w_timeout)
                r_tcnt <= '0;
            else if (w_overrun && !mem_ack)
                r_tcnt <= r_tcnt + 1'b1;

            if (w_timeout)
                r_timeout_err <= 1'b1;

            if (w_in_cpu && w_done && !mem_we)
                r_cpu_rdata <= mem_rdata;
            else if (w_in_cpu && w_timeout)
                r_cpu_rdata <= c_bus_err_fill;

            if (w_in_dma && w_done && !mem_we)
                r_chip_rdata <= mem_rdata;
            else if (w_in_dma && w_timeout)
                r_chip_rdata <= c_bus_err_fill;

            // bls tracks whether a waiting CPU lost this slot to DMA.
            if (clk7_en) begin
                if (!cpu_req || w_accept_cpu)
                    r_bls <= 1'b0;
                else if ((w_idle && dbr) || w_in_dma)
                    r_bls <= 1'b1;
            end
        end
    end

    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;
    assign chip_rdata  = r_chip_rdata;
    assign bls         = r_bls;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_agnus_chipbus_seq.sv
`default_nettype none
// ============================================================================
//  tb_agnus_chipbus_seq
//  Directed self-checking bench for the chip-bus cycle sequencer.
//  Revision: 1.0
// ============================================================================
module tb_agnus_chipbus_seq;

    logic        clk = 1'b0;
    logic        _reset;
    logic        clk7_en, dbr, dbwe, cpu_req, cpu_we, cpu_uds, cpu_lds, mem_ack;
    logic [19:0] dma_address, cpu_address;
    logic [15:0] dma_wdata, cpu_wdata, mem_rdata;
    logic        cpu_ack, mem_req, mem_we, bls, timeout_err;
    logic [15:0] cpu_rdata, chip_rdata, mem_wdata;
    logic [19:0] mem_address;
    logic [1:0]  mem_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    agnus_chipbus_seq dut (
        .clk(clk), ._reset(_reset), .clk7_en(clk7_en), .dbr(dbr), .dbwe(dbwe),
        .dma_address(dma_address), .dma_wdata(dma_wdata), .cpu_req(cpu_req),
        .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .chip_rdata(chip_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bls(bls),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clk with a slot tick present at the sampling edge.
    task automatic slot();
        clk7_en = 1'b1;
        step();
        clk7_en = 1'b0;
    endtask

    initial begin
        _reset = 1'b0; clk7_en = 0; dbr = 0; dbwe = 0; cpu_req = 0; cpu_we = 0;
        cpu_uds = 0; cpu_lds = 0; mem_ack = 0; dma_address = '0; cpu_address = '0;
        dma_wdata = '0; cpu_wdata = '0; mem_rdata = '0;
        step(); step();
        _reset = 1'b1;
        step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_chip_rdata", {16'd0, chip_rdata}, 32'd0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_flags", {30'd0, bls, timeout_err}, 32'd0);
        chk("rst_mem_be", {30'd0, mem_be}, 32'd0);

        // DMA read, acked two clocks after the slot
        dbr = 1; dbwe = 0; dma_address = 20'h00100;
        slot(); dbr = 0;
        chk("dma_rd_req", {31'd0, mem_req}, 32'd1);
        chk("dma_rd_addr", {12'd0, mem_address}, 32'h00100);
        chk("dma_rd_be_we", {29'd0, mem_be, mem_we}, {29'd0, 3'b110});
        step();
        chk("dma_rd_req2", {31'd0, mem_req}, 32'd1);
        mem_ack = 1; mem_rdata = 16'h1234;
        step(); mem_ack = 0;
        chk("dma_rd_req_drop", {31'd0, mem_req}, 32'd0);
        chk("dma_rd_data", {16'd0, chip_rdata}, 32'h1234);
        chk("dma_rd_no_ack", {31'd0, cpu_ack}, 32'd0);

        // CPU lower-byte write
        cpu_req = 1; cpu_we = 1; cpu_uds = 0; cpu_lds = 1;
        cpu_wdata = 16'h00AB; cpu_address = 20'h00200;
        slot();
        chk("cpu_wr_be", {30'd0, mem_be}, 32'd1);
        chk("cpu_wr_we", {31'd0, mem_we}, 32'd1);
        chk("cpu_wr_wdata", {16'd0, mem_wdata}, 32'h00AB);
        chk("cpu_wr_addr", {12'd0, mem_address}, 32'h00200);
        mem_ack = 1; mem_rdata = 16'h9999;
        step(); mem_ack = 0;
        chk("cpu_wr_ack", {31'd0, cpu_ack}, 32'd1);
        chk("cpu_wr_rdata_hold", {16'd0, cpu_rdata}, 32'h0000);
        cpu_req = 0;
        step();
        chk("cpu_wr_ack_pulse", {31'd0, cpu_ack}, 32'd0);

        // Contention: three DMA slots win over a waiting CPU read
        cpu_req = 1; cpu_we = 0; cpu_uds = 1; cpu_lds = 1; cpu_address = 20'h00300;
        for (int k = 0; k < 3; k++) begin
            dbr = 1; dbwe = 0; dma_address = 20'h00400 + 20'(k);
            slot(); dbr = 0;
            chk("cont_dma_addr", {12'd0, mem_address}, 32'h00400 + k);
            chk("cont_bls", {31'd0, bls}, 32'd1);
            mem_ack = 1; mem_rdata = 16'hA000 + 16'(k);
            step(); mem_ack = 0;
            chk("cont_chip_rdata", {16'd0, chip_rdata}, 32'hA000 + k);
            chk("cont_no_cpu_ack", {31'd0, cpu_ack}, 32'd0);
            step();
        end
        slot();
        chk("cont_cpu_addr", {12'd0, mem_address}, 32'h00300);
        chk("cont_cpu_be_we", {29'd0, mem_be, mem_we}, {29'd0, 3'b110});
        chk("cont_bls_clear", {31'd0, bls}, 32'd0);
        mem_ack = 1; mem_rdata = 16'h5678;
        step(); mem_ack = 0; cpu_req = 0;
        chk("cont_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("cont_cpu_rdata", {16'd0, cpu_rdata}, 32'h5678);
        step();

        // Back-to-back: ack coincides with a slot tick, that slot is lost
        dbr = 1; dbwe = 1; dma_address = 20'h00500; dma_wdata = 16'hBEEF;
        slot();
        chk("b2b_wr_we", {31'd0, mem_we}, 32'd1);
        chk("b2b_wr_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        dbwe = 0; dma_address = 20'h00600;
        mem_ack = 1;
        slot(); mem_ack = 0;
        chk("b2b_slot_lost", {31'd0, mem_req}, 32'd0);
        chk("b2b_wr_chip_hold", {16'd0, chip_rdata}, 32'hA002);
        step();
        chk("b2b_still_idle", {31'd0, mem_req}, 32'd0);
        slot(); dbr = 0;
        chk("b2b_next_req", {31'd0, mem_req}, 32'd1);
        chk("b2b_next_addr", {12'd0, mem_address}, 32'h00600);
        mem_ack = 1; mem_rdata = 16'h1111;
        step(); mem_ack = 0;
        chk("b2b_next_data", {16'd0, chip_rdata}, 32'h1111);

        // Timeout: CPU read never acknowledged
        cpu_req = 1; cpu_we = 0; cpu_address = 20'h00700;
        slot();
        chk("to_req", {31'd0, mem_req}, 32'd1);
        for (int t = 0; t < 14; t++) begin
            step();
            slot();
        end
        chk("to_req_before", {31'd0, mem_req}, 32'd1);
        chk("to_no_err_before", {31'd0, timeout_err}, 32'd0);
        step();
        slot();
        cpu_req = 0;
        chk("to_req_drop", {31'd0, mem_req}, 32'd0);
        chk("to_cpu_ack", {31'd0, cpu_ack}, 32'd1);
        chk("to_cpu_rdata", {16'd0, cpu_rdata}, 32'hFFFF);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        step();
        chk("to_ack_pulse", {31'd0, cpu_ack}, 32'd0);
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset mid-transaction while a CPU waits behind DMA
        cpu_req = 1; cpu_we = 1; cpu_uds = 0; cpu_lds = 0;
        cpu_address = 20'h00800; cpu_wdata = 16'h4242;
        dbr = 1; dbwe = 0; dma_address = 20'h00900;
        slot(); dbr = 0;
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        chk("mid_bls", {31'd0, bls}, 32'd1);
        #2 _reset = 1'b0;
        #1;
        chk("async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_flags", {29'd0, cpu_ack, bls, timeout_err}, 32'd0);
        step();
        _reset = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, mem_req}, 32'd0);
        slot();
        chk("post_rst_req", {31'd0, mem_req}, 32'd1);
        chk("post_rst_addr", {12'd0, mem_address}, 32'h00800);
        chk("post_rst_be", {30'd0, mem_be}, 32'd3);
        mem_ack = 1;
        step(); mem_ack = 0; cpu_req = 0;
        chk("post_rst_ack", {31'd0, cpu_ack}, 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
